// File: rtl/rotary_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : rotary_ctrl_multi_if
// Description : Bundle of the per-channel request and position signals of
//               rotary_ctrl_multi.
//               master = request side (input mapper / testbench),
//               slave  = rotary_ctrl_multi.
// Signals     : cw, ccw           raw rotate requests, one bit per channel
//               abs_en            channel runs in absolute (target) mode
//               abs_valid         one-cycle strobe qualifying abs_target
//               abs_target        NCH x PW packed target positions
//               rotary            NCH x POSITIONS packed one-hot positions
//               pos               NCH x PW packed binary positions
//               step_pulse        one-cycle strobe per channel on each step
// Revision    : 1.0  initial release
// ============================================================================
interface rotary_ctrl_multi_if #(
    parameter int NCH       = 2,
    parameter int POSITIONS = 12,
    parameter int PW        = 4
);
    logic [NCH-1:0]           cw;
    logic [NCH-1:0]           ccw;
    logic [NCH-1:0]           abs_en;
    logic [NCH-1:0]           abs_valid;
    logic [NCH*PW-1:0]        abs_target;
    logic [NCH*POSITIONS-1:0] rotary;
    logic [NCH*PW-1:0]        pos;
    logic [NCH-1:0]           step_pulse;

    modport master (
        output cw, ccw, abs_en, abs_valid, abs_target,
        input  rotary, pos, step_pulse
    );

    modport slave (
        input  cw, ccw, abs_en, abs_valid, abs_target,
        output rotary, pos, step_pulse
    );
endinterface
`default_nettype wire

// File: rtl/rotary_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : rotary_ctrl_multi
// Description : Multi-channel rotary-joystick position generator. Each channel
//               synchronises and debounces its cw/ccw requests, steps once
//               per press with optional hold-to-repeat, or in absolute mode
//               walks toward a latched target by the shortest path.
//               All timing is counted in ticks of a shared prescaler.
// Ports       : clk_sys   system clock
//               reset_n   asynchronous active-low reset
//               bus       rotary_ctrl_multi_if.slave (requests in,
//                         rotary/pos/step_pulse out)
// Revision    : 1.0  initial release
// ============================================================================
module rotary_ctrl_multi #(
    parameter int NCH          = 2,
    parameter int POSITIONS    = 12,
    parameter int PW           = 4,
    parameter int TICK_DIV     = 72000,
    parameter int DEB_TICKS    = 2,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 60,
    parameter int AUTO_REPEAT  = 1
) (
    input  wire                     clk_sys,
    input  wire                     reset_n,
    rotary_ctrl_multi_if.slave      bus
);

    localparam int c_TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RW   = $clog2(c_RMAX + 1);

    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   c_LAST      = PW'(POSITIONS - 1);
    localparam logic [PW:0]     c_NPOS      = (PW+1)'(POSITIONS);
    localparam logic [PW:0]     c_HALF      = (PW+1)'(POSITIONS / 2);
    localparam logic [c_RW-1:0] c_RDLY      = c_RW'(REPEAT_DELAY);
    localparam logic [c_RW-1:0] c_RRATE     = c_RW'(REPEAT_RATE);

    // ------------------------------------------------------------------
    // Shared tick prescaler
    // ------------------------------------------------------------------
    logic [c_TW-1:0] r_presc;
    logic            w_tick;

    assign w_tick = (r_presc == c_TICK_LAST);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    logic [NCH*POSITIONS-1:0] w_rot_all;
    logic [NCH*PW-1:0]        w_pos_all;
    logic [NCH-1:0]           w_step_all;

    // ------------------------------------------------------------------
    // Per-channel logic
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        // index 0 = cw, index 1 = ccw throughout this block
        logic [1:0]           w_raw;
        logic [1:0]           r_s1;
        logic [1:0]           r_s2;
        logic [1:0]           w_lvl;
        logic [1:0]           r_lvl_d;
        logic [1:0]           w_rise;
        logic                 w_abs;
        logic [PW-1:0]        w_tgt_in;
        logic [PW-1:0]        r_pos;
        logic [POSITIONS-1:0] r_rot;
        logic                 r_step;
        logic [PW-1:0]        r_tgt;
        logic                 r_tgt_vld;
        logic                 r_arm;
        logic [c_RW-1:0]      r_rtmr;
        logic [c_RW-1:0]      r_atmr;
        logic [PW:0]          w_dist;
        logic                 w_abs_go;
        logic                 w_abs_cw;
        logic                 w_step;
        logic                 w_step_cw;

        assign w_raw    = {bus.ccw[gi], bus.cw[gi]};
        assign w_abs    = bus.abs_en[gi];
        assign w_tgt_in = bus.abs_target[gi*PW +: PW];

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_s1 <= '0;
                r_s2 <= '0;
            end else begin
                r_s1 <= w_raw;
                r_s2 <= r_s1;
            end
        end

        if (DEB_TICKS == 0) begin : g_deb_bypass
            assign w_lvl = r_s2;
        end else begin : g_deb
            localparam int c_DW = $clog2(DEB_TICKS + 1);
            for (genvar gk = 0; gk < 2; gk++) begin : g_in
                logic            r_prev;
                logic            r_level;
                logic [c_DW-1:0] r_cnt;

                // r_cnt counts ticks since the synchronised value last
                // changed; it only runs while that value differs from
                // the current debounced level.
                always_ff @(posedge clk_sys or negedge reset_n) begin
                    if (!reset_n) begin
                        r_prev  <= 1'b0;
                        r_level <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_prev <= r_s2[gk];
                        if (r_s2[gk] != r_prev || r_s2[gk] == r_level) begin
                            r_cnt <= '0;
                        end else if (w_tick) begin
                            if (r_cnt == c_DW'(DEB_TICKS - 1)) begin
                                r_level <= r_s2[gk];
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                end

                assign w_lvl[gk] = r_level;
            end
        end

        // Edge history keeps tracking in absolute mode, so a request that is
        // still held when the channel returns to manual mode has no edge.
        assign w_rise = w_lvl & ~r_lvl_d;

        // Forward (ccw) distance from pos to the latched target, mod POSITIONS
        always_comb begin
            w_dist = '0;
            if (r_tgt >= r_pos) begin
                w_dist = {1'b0, r_tgt} - {1'b0, r_pos};
            end else begin
                w_dist = {1'b0, r_tgt} + c_NPOS - {1'b0, r_pos};
            end
        end

        assign w_abs_go = r_tgt_vld && (w_dist != '0);
        assign w_abs_cw = (w_dist >= c_HALF);

        always_comb begin
            w_step    = 1'b0;
            w_step_cw = 1'b0;
            if (w_abs) begin
                if (w_abs_go && (r_atmr == '0)) begin
                    w_step    = 1'b1;
                    w_step_cw = w_abs_cw;
                end
            end else if (w_lvl != 2'b11) begin
                if (w_rise[0]) begin
                    w_step    = 1'b1;
                    w_step_cw = 1'b1;
                end else if (w_rise[1]) begin
                    w_step    = 1'b1;
                    w_step_cw = 1'b0;
                end else if (r_arm && (w_lvl != 2'b00) && (r_rtmr == '0)) begin
                    w_step    = 1'b1;
                    w_step_cw = w_lvl[0];
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                r_lvl_d   <= '0;
                r_pos     <= '0;
                r_rot     <= POSITIONS'(1);
                r_step    <= 1'b0;
                r_tgt     <= '0;
                r_tgt_vld <= 1'b0;
                r_arm     <= 1'b0;
                r_rtmr    <= '0;
                r_atmr    <= '0;
            end else begin
                r_lvl_d <= w_lvl;
                r_step  <= w_step;

                if (w_step) begin
                    if (w_step_cw) begin
                        r_pos <= (r_pos == '0) ? c_LAST : r_pos - 1'b1;
                        r_rot <= {r_rot[0], r_rot[POSITIONS-1:1]};
                    end else begin
                        r_pos <= (r_pos == c_LAST) ? '0 : r_pos + 1'b1;
                        r_rot <= {r_rot[POSITIONS-2:0], r_rot[POSITIONS-1]};
                    end
                end

                // Out-of-range targets are dropped; the old target stays.
                if (!w_abs) begin
                    r_tgt_vld <= 1'b0;
                end else if (bus.abs_valid[gi] && ({1'b0, w_tgt_in} < c_NPOS)) begin
                    r_tgt     <= w_tgt_in;
                    r_tgt_vld <= 1'b1;
                end

                // Absolute timer is cleared once on target, so the next
                // latch steps right away; a mid-travel retarget keeps it.
                if (!w_abs || !w_abs_go) begin
                    r_atmr <= '0;
                end else if (w_step) begin
                    r_atmr <= c_RRATE;
                end else if (w_tick && (r_atmr != '0)) begin
                    r_atmr <= r_atmr - 1'b1;
                end

                if (w_abs || (w_lvl == 2'b11) || (w_lvl == 2'b00)) begin
                    r_arm  <= 1'b0;
                    r_rtmr <= '0;
                end else if (w_step) begin
                    r_arm  <= (AUTO_REPEAT != 0);
                    r_rtmr <= (w_rise != 2'b00) ? c_RDLY : c_RRATE;
                end else if (w_tick && (r_rtmr != '0)) begin
                    r_rtmr <= r_rtmr - 1'b1;
                end
            end
        end

        assign w_rot_all[gi*POSITIONS +: POSITIONS] = r_rot;
        assign w_pos_all[gi*PW +: PW]               = r_pos;
        assign w_step_all[gi]                       = r_step;
    end

    assign bus.rotary     = w_rot_all;
    assign bus.pos        = w_pos_all;
    assign bus.step_pulse = w_step_all;

endmodule
`default_nettype wire

// File: tb/tb_rotary_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_ctrl_multi
// Description : Self-checking bench for rotary_ctrl_multi. Directed manual
//               and absolute-mode scenarios plus randomised absolute targets
//               compared against a shortest-path position model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rotary_ctrl_multi;

    localparam int NCH = 2;
    localparam int NP  = 12;
    localparam int PW  = 4;
    localparam int TD  = 4;
    localparam int RR  = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   cyc;
    int   q_t [NCH][$];
    int   q_p [NCH][$];
    int   mpos [NCH];

    rotary_ctrl_multi_if #(.NCH(NCH), .POSITIONS(NP), .PW(PW)) bus ();

    rotary_ctrl_multi #(
        .NCH(NCH), .POSITIONS(NP), .PW(PW), .TICK_DIV(TD), .DEB_TICKS(2),
        .REPEAT_DELAY(3), .REPEAT_RATE(RR), .AUTO_REPEAT(1)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Step recorder: cycle index and new position of every step_pulse.
    initial cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < NCH; c++) begin
            if (bus.step_pulse[c]) begin
                q_t[c].push_back(cyc);
                q_p[c].push_back(int'(bus.pos[c*PW +: PW]));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk = n_chk + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] oh(input int p);
        oh = 32'd1 << p;
    endfunction

    task automatic clrq();
        for (int c = 0; c < NCH; c++) begin
            q_t[c].delete();
            q_p[c].delete();
        end
    endtask

    task automatic chk_ch(input string tag, input int ch, input int p);
        chk({tag, "_pos"}, 32'(bus.pos[ch*PW +: PW]), p);
        chk({tag, "_rot"}, 32'(bus.rotary[ch*NP +: NP]), oh(p));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wt(2);
        rst_n = 1'b1;
        wt(1);
        mpos[0] = 0;
        mpos[1] = 0;
    endtask

    // Expected walk: one step at a time toward tgt, ccw when the forward
    // distance is under half a turn, cw otherwise.
    task automatic check_path(input string tag, input int ch, input int start,
                              input int tgt, input int t0);
        int p;
        int d;
        int e[$];
        p = start;
        while (p != tgt) begin
            d = (tgt - p + NP) % NP;
            p = (d < NP/2) ? (p + 1) % NP : (p + NP - 1) % NP;
            e.push_back(p);
        end
        chk({tag, "_nsteps"}, q_p[ch].size(), e.size());
        for (int i = 0; i < e.size() && i < q_p[ch].size(); i++)
            chk($sformatf("%s_step%0d", tag, i), q_p[ch][i], e[i]);
        if (q_t[ch].size() > 0)
            chk({tag, "_first_t"}, q_t[ch][0] - t0, 2);
        if (q_t[ch].size() > 1)
            chk({tag, "_gap1_ok"},
                ((q_t[ch][1] - q_t[ch][0]) >= (RR-1)*TD + 1) &&
                ((q_t[ch][1] - q_t[ch][0]) <= RR*TD + 1), 1);
        for (int i = 2; i < q_t[ch].size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), q_t[ch][i] - q_t[ch][i-1], RR*TD);
        chk_ch({tag, "_end"}, ch, tgt);
    endtask

    task automatic strobe(input logic [NCH-1:0] v, input int t0v, input int t1v, output int t0);
        bus.abs_target = {4'(t1v), 4'(t0v)};
        bus.abs_valid  = v;
        t0 = cyc;
        wt(1);
        bus.abs_valid  = '0;
    endtask

    initial begin
        int t0;
        int tg [NCH];
        int st [NCH];
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.cw = '0;
        bus.ccw = '0;
        bus.abs_en = '0;
        bus.abs_valid = '0;
        bus.abs_target = '0;
        wt(3);
        rst_n = 1'b1;
        wt(1);
        mpos[0] = 0;
        mpos[1] = 0;

        // Reset state
        chk("rst_rotary", 32'(bus.rotary), 32'h001001);
        chk("rst_pos", 32'(bus.pos), 0);
        chk("rst_step", 32'(bus.step_pulse), 0);

        // One-tick glitch is rejected by the debouncer
        clrq();
        bus.cw[0] = 1'b1;
        wt(TD);
        bus.cw[0] = 1'b0;
        wt(24);
        chk("glitch_nsteps", q_t[0].size(), 0);
        chk_ch("glitch", 0, 0);

        // Held cw: single step, then repeat after 12 cycles, then every 8
        clrq();
        t0 = cyc;
        bus.cw[0] = 1'b1;
        wt(2*TD + 4);
        chk("hold_nsteps", q_t[0].size(), 1);
        if (q_t[0].size() > 0)
            chk("hold_latency_ok", (q_t[0][0] - t0) <= 2*TD + 4, 1);
        chk_ch("hold_ch0", 0, 11);
        chk_ch("hold_ch1", 1, 0);
        wt(40);
        chk("rep_nsteps", q_t[0].size(), 5);
        for (int i = 0; i < 5 && i < q_p[0].size(); i++)
            chk($sformatf("rep_pos%0d", i), q_p[0][i], 11 - i);
        if (q_t[0].size() > 1)
            chk("rep_delay", q_t[0][1] - q_t[0][0], 12);
        for (int i = 2; i < q_t[0].size(); i++)
            chk($sformatf("rep_gap%0d", i), q_t[0][i] - q_t[0][i-1], 8);
        chk("rep_ch1_nsteps", q_t[1].size(), 0);
        bus.cw[0] = 1'b0;
        wt(20);

        // Channel 1: simultaneous cw+ccw, partial release, fresh press
        clrq();
        bus.cw[1] = 1'b1;
        bus.ccw[1] = 1'b1;
        wt(30);
        chk("both_nsteps", q_t[1].size(), 0);
        bus.ccw[1] = 1'b0;
        wt(30);
        chk("release_one_nsteps", q_t[1].size(), 0);
        bus.cw[1] = 1'b0;
        wt(20);
        clrq();
        bus.cw[1] = 1'b1;
        wt(2*TD + 4);
        chk("repress_nsteps", q_t[1].size(), 1);
        chk_ch("repress", 1, 11);
        bus.cw[1] = 1'b0;

        // Absolute mode, directed targets
        do_reset();
        chk("rst2_rotary", 32'(bus.rotary), 32'h001001);
        bus.abs_en[0] = 1'b1;
        wt(2);
        clrq();
        strobe(2'b01, 3, 0, t0);
        wt(40);
        check_path("abs3", 0, 0, 3, t0);
        clrq();
        strobe(2'b01, 9, 0, t0);
        wt(60);
        check_path("abs9", 0, 3, 9, t0);
        mpos[0] = 9;

        // Randomised absolute targets on both channels
        bus.abs_en = 2'b11;
        wt(2);
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < NCH; c++) begin
                st[c] = mpos[c];
                tg[c] = int'($urandom_range(0, 15));
            end
            clrq();
            strobe(2'b11, tg[0], tg[1], t0);
            wt(64);
            for (int c = 0; c < NCH; c++) begin
                if (tg[c] < NP) mpos[c] = tg[c];
                check_path($sformatf("rnd%0d_ch%0d", it, c), c, st[c], mpos[c], t0);
            end
        end

        // Out-of-range target is ignored
        clrq();
        strobe(2'b01, 13, 0, t0);
        wt(20);
        chk("bad_tgt_nsteps", q_t[0].size(), 0);
        chk_ch("bad_tgt", 0, mpos[0]);

        // Reset during travel
        clrq();
        strobe(2'b01, (mpos[0] + 6) % NP, 0, t0);
        for (int k = 0; k < 40 && q_t[0].size() < 2; k++) wt(1);
        chk("midtravel_reached", q_t[0].size() >= 2, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rotary", 32'(bus.rotary), 32'h001001);
        chk("async_rst_pos", 32'(bus.pos), 0);
        chk("async_rst_step", 32'(bus.step_pulse), 0);
        clrq();
        wt(4);
        chk("in_rst_nsteps", q_t[0].size() + q_t[1].size(), 0);
        rst_n = 1'b1;
        wt(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
